bin_to_bcd_seq: RTL and testbench

- Parametrised, multi-cycle binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm.
- Generalises the earlier 4-bit combinational converter to WIDTH-bit inputs and DIGITS decimal digits.
- Uses valid/ready handshakes on input and output, and an optional leading-zero blanking mode.
- Drives per-digit 7-segment outputs for the board display path.

---
 rtl/bcd_pkg.sv | 35 +++
 rtl/bcd_to_7seg.sv | 14 +
 rtl/bin_to_bcd_seq.sv | 116 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter
// and its 7-segment digit decoder.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns, index = decimal digit.
    localparam logic [9:0][6:0] SEG_LUT = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // Decimal digits needed to show the largest WIDTH-bit unsigned value.
    function automatic int min_digits(input int width);
        logic [63:0] v;
        int          n;
        v = (64'd1 << width) - 64'd1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (v != 64'd0) begin
                n++;
                v = v / 64'd10;
            end
        end
        if (n == 0) n = 1;
        return n;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// One BCD digit to an active-low 7-segment pattern; codes 10..15 go blank.
module bcd_to_7seg
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (digit < 4'd10) seg = SEG_LUT[digit];
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Multi-cycle double-dabble binary-to-BCD converter with valid/ready
// handshakes, leading-zero blanking and per-digit 7-segment outputs.
//
// state | meaning
// IDLE  | waiting for in_valid; in_ready=1
// CONV  | one add-3/shift step per clock, WIDTH steps total
// DONE  | result held on bcd with out_valid=1 until out_ready
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  lz_blank,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   segments
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    generate
        if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
            $error("bin_to_bcd_seq: WIDTH must be within 4..32");
        end
        if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
            $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
        end
    endgenerate

    state_t            state;
    logic [SR_W-1:0]   sr;
    logic [SR_W-1:0]   sr_corr;
    logic [SR_W-1:0]   sr_shift;
    logic [CNT_W-1:0]  count;
    logic [DIGITS-1:0] blank;
    logic              seen_nz;
    logic [7*DIGITS-1:0] seg_raw;

    // Digits are corrected independently; no carry crosses a digit boundary.
    always_comb begin
        sr_corr = sr;
        for (int i = 0; i < DIGITS; i++) begin
            if (sr[WIDTH+4*i +: 4] >= 4'd5)
                sr_corr[WIDTH+4*i +: 4] = sr[WIDTH+4*i +: 4] + 4'd3;
        end
        sr_shift = {sr_corr[SR_W-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            bcd       <= '0;
            sr        <= '0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sr    <= SR_W'(bin);
                        count <= CNT_W'(WIDTH);
                        state <= CONV;
                    end
                end
                CONV: begin
                    sr    <= sr_shift;
                    count <= count - 1'b1;
                    if (count == CNT_W'(1)) begin
                        bcd       <= sr_shift[SR_W-1 -: BCD_W];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready = (state == IDLE);

    // Walk down from the top digit; blank until the first nonzero digit.
    always_comb begin
        blank   = '0;
        seen_nz = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (bcd[4*i +: 4] != 4'd0) seen_nz = 1'b1;
            blank[i] = lz_blank & ~seen_nz;
        end
    end

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            bcd_to_7seg u_seg (
                .digit (bcd[4*g +: 4]),
                .seg   (seg_raw[7*g +: 7])
            );
            assign segments[7*g +: 7] = seg_raw[7*g +: 7] | {7{blank[g]}};
        end
    endgenerate

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: fixed vectors, hand-written
// handshake/reset sequences and random values against an arithmetic model.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, lz_blank;
    logic [7:0]  bin;
    logic [11:0] bcd;
    logic [20:0] segments;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_lz_blank;
    logic [15:0] w_bin;
    logic [19:0] w_bcd;
    logic [34:0] w_segments;

    int vectors    = 0;
    int miscompares = 0;

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .lz_blank(lz_blank), .bcd(bcd), .segments(segments)
    );

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .bin(w_bin), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .lz_blank(w_lz_blank), .bcd(w_bcd), .segments(w_segments)
    );

    typedef struct {
        logic [7:0]  b;
        logic        lz;
        logic [11:0] eb;
        logic [20:0] es;
    } vec_t;

    vec_t vt[7];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [63:0] ref_bcd(input longint unsigned v, input int nd);
        logic [63:0] r = '0;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [63:0] ref_seg(input longint unsigned v, input int nd, input logic lz);
        logic [63:0]     r = '0;
        longint unsigned t = v;
        int              msd = 0;
        for (int i = 0; i < nd; i++) begin
            if (t % 10 != 0) msd = i;
            t = t / 10;
        end
        t = v;
        for (int i = 0; i < nd; i++) begin
            r[7*i +: 7] = (lz && i > msd) ? 7'h7F : seg_of(int'(t % 10));
            t = t / 10;
        end
        return r;
    endfunction

    task automatic conv8(input logic [7:0] b, input logic lz, output int lat);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) check("in_ready_wait", in_ready, 1);
        in_valid = 1; bin = b; lz_blank = lz; out_ready = 0;
        @(negedge clk);
        in_valid = 0; bin = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    endtask

    task automatic release8();
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        check("handoff_clears_valid", out_valid, 0);
    endtask

    task automatic conv16(input logic [15:0] b, input logic lz, output int lat);
        int n = 0;
        @(negedge clk);
        while (!w_in_ready && n < 50) begin @(negedge clk); n++; end
        if (!w_in_ready) check("w_in_ready_wait", w_in_ready, 1);
        w_in_valid = 1; w_bin = b; w_lz_blank = lz; w_out_ready = 0;
        @(negedge clk);
        w_in_valid = 0; w_bin = 16'($urandom);
        lat = 0;
        while (!w_out_valid && lat < 60) begin @(negedge clk); lat++; end
    endtask

    task automatic release16();
        w_out_ready = 1;
        @(negedge clk);
        w_out_ready = 0;
        check("w_handoff_clears_valid", w_out_valid, 0);
    endtask

    initial begin
        int lat;
        logic [7:0] rb;
        logic [15:0] rw;
        logic rl;

        vt[0] = '{8'd255, 1'b0, 12'h255, {7'h24, 7'h12, 7'h12}};
        vt[1] = '{8'd0,   1'b1, 12'h000, {7'h7F, 7'h7F, 7'h40}};
        vt[2] = '{8'd9,   1'b1, 12'h009, {7'h7F, 7'h7F, 7'h10}};
        vt[3] = '{8'd9,   1'b0, 12'h009, {7'h40, 7'h40, 7'h10}};
        vt[4] = '{8'd100, 1'b1, 12'h100, {7'h79, 7'h40, 7'h40}};
        vt[5] = '{8'd37,  1'b1, 12'h037, {7'h7F, 7'h30, 7'h78}};
        vt[6] = '{8'd80,  1'b1, 12'h080, {7'h7F, 7'h00, 7'h40}};

        rst_n = 0; in_valid = 0; out_ready = 0; lz_blank = 0; bin = '0;
        w_in_valid = 0; w_out_ready = 0; w_lz_blank = 0; w_bin = '0;
        #12;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_bcd", bcd, 0);
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 7; i++) begin
            conv8(vt[i].b, vt[i].lz, lat);
            check("table_latency", lat, 8);
            check("table_bcd", bcd, vt[i].eb);
            check("table_segments", segments, vt[i].es);
            release8();
        end

        // Result stays on bcd after handoff; blanking is live.
        conv8(8'd9, 1'b1, lat);
        check("nine_lz1_segments", segments, {7'h7F, 7'h7F, 7'h10});
        release8();
        lz_blank = 0;
        #1;
        check("nine_held_bcd", bcd, 12'h009);
        check("nine_lz0_segments", segments, {7'h40, 7'h40, 7'h10});

        for (int i = 0; i < 30; i++) begin
            rb = 8'($urandom_range(0, 255));
            rl = 1'($urandom_range(0, 1));
            conv8(rb, rl, lat);
            check("rand_latency", lat, 8);
            check("rand_bcd", bcd, ref_bcd(rb, 3));
            check("rand_segments", segments, ref_seg(rb, 3, rl));
            release8();
        end

        // Back-pressure: result held, in_valid ignored during DONE.
        conv8(8'd128, 1'b0, lat);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1; bin = 8'd77;
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_bcd", bcd, 12'h128);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1;
        @(negedge clk);
        out_ready = 0; in_valid = 0;
        check("bp_release_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_bcd", bcd, 12'h128);
        conv8(8'd77, 1'b0, lat);
        check("bp_next_latency", lat, 8);
        check("bp_next_bcd", bcd, 12'h077);
        release8();

        // Async reset during CONV.
        @(negedge clk);
        in_valid = 1; bin = 8'd200;
        @(negedge clk);
        in_valid = 0;
        repeat (4) @(negedge clk);
        #2 rst_n = 0;
        #1;
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_bcd", bcd, 0);
        check("rst_mid_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1;
        conv8(8'd37, 1'b0, lat);
        check("after_rst_latency", lat, 8);
        check("after_rst_bcd", bcd, 12'h037);
        release8();

        // 16-bit instance.
        conv16(16'd65535, 1'b0, lat);
        check("w_latency", lat, 16);
        check("w_bcd_max", w_bcd, 20'h65535);
        release16();
        conv16(16'd1, 1'b1, lat);
        check("w_bcd_one", w_bcd, 20'h00001);
        check("w_seg_one", w_segments, ref_seg(1, 5, 1'b1));
        release16();
        conv16(16'd10000, 1'b1, lat);
        check("w_bcd_10000", w_bcd, 20'h10000);
        release16();
        for (int i = 0; i < 8; i++) begin
            rw = 16'($urandom);
            rl = 1'($urandom_range(0, 1));
            conv16(rw, rl, lat);
            check("w_rand_latency", lat, 16);
            check("w_rand_bcd", w_bcd, ref_bcd(rw, 5));
            check("w_rand_segments", w_segments, ref_seg(rw, 5, rl));
            release16();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
